// File: rtl/seq_addsub_unit.sv
// seq_addsub_unit
//   Multi-cycle WIDTH-bit adder/subtractor. Operands are processed CHUNK bits
//   per clock, least-significant slice first, with a registered carry between
//   slices. A start/done handshake frames each operation.
//
//   Optional build macro: ADDSUB_SAT_EN
//     defined   -> signed saturation of out on overflow (flags stay raw,
//                  zero follows the saturated out)
//     undefined -> out is the wrapped modulo-2^WIDTH result
//
//   Ports
//     clk       in   clock, rising edge
//     rst_n     in   synchronous active-low reset
//     start     in   operation request, sampled only in IDLE
//     in1       in   operand A
//     in2       in   operand B
//     c_in      in   0 = A+B, 1 = A-B
//     busy      out  high while not IDLE
//     done      out  one-cycle completion pulse
//     out       out  result, held until the next completion
//     carry     out  carry out of the MSB (subtract: 1 = no borrow)
//     overflow  out  signed two's-complement overflow
//     zero      out  out == 0
//
//   state   | meaning
//   IDLE    | waiting for start, operands not yet captured
//   RUN     | one slice added per clock, down-counter selects the last slice
//   DONE    | results published, done high for this single cycle
module seq_addsub_unit #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             carry,
    output logic             overflow,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CNTW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]       state;
    logic [CNTW-1:0]  cnt;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] acc;
    logic             cy;
    logic             a_msb;
    logic             b_msb;

    logic [CHUNK:0]   slice_sum;
    logic [WIDTH-1:0] acc_next;
    logic [WIDTH-1:0] a_next;
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] res_fin;
    logic             last;
    logic             raw_ovf;

    // The operand registers shift right so the active slice is always the low
    // CHUNK bits; the accumulator shifts in from the top so that after NCHUNK
    // slices the result sits in natural bit order.
    assign slice_sum = {1'b0, a_sh[CHUNK-1:0]} + {1'b0, b_sh[CHUNK-1:0]}
                     + {{CHUNK{1'b0}}, cy};

    generate
        if (NCHUNK == 1) begin : g_single
            assign acc_next = slice_sum[CHUNK-1:0];
            assign a_next   = a_sh;
            assign b_next   = b_sh;
        end else begin : g_multi
            assign acc_next = {slice_sum[CHUNK-1:0], acc[WIDTH-1:CHUNK]};
            assign a_next   = {{CHUNK{1'b0}}, a_sh[WIDTH-1:CHUNK]};
            assign b_next   = {{CHUNK{1'b0}}, b_sh[WIDTH-1:CHUNK]};
        end
    endgenerate

    assign last    = (cnt == '0);
    assign raw_ovf = (a_msb == b_msb) && (slice_sum[CHUNK-1] != a_msb);

`ifdef ADDSUB_SAT_EN
    assign res_fin = !raw_ovf ? acc_next
                   : (a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}});
`else
    assign res_fin = acc_next;
`endif

    assign busy = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            a_sh     <= '0;
            b_sh     <= '0;
            acc      <= '0;
            cy       <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            done     <= 1'b0;
            out      <= '0;
            carry    <= 1'b0;
            overflow <= 1'b0;
            zero     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sh  <= in1;
                        b_sh  <= c_in ? ~in2 : in2;
                        a_msb <= in1[WIDTH-1];
                        b_msb <= in2[WIDTH-1] ^ c_in;
                        cy    <= c_in;
                        cnt   <= CNTW'(NCHUNK - 1);
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh <= a_next;
                    b_sh <= b_next;
                    acc  <= acc_next;
                    cy   <= slice_sum[CHUNK];
                    cnt  <= cnt - 1'b1;
                    if (last) begin
                        out      <= res_fin;
                        carry    <= slice_sum[CHUNK];
                        overflow <= raw_ovf;
                        zero     <= (res_fin == '0);
                        done     <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_addsub_unit.sv
module tb_seq_addsub_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    // main instance: WIDTH=32, CHUNK=8
    logic        start, c_in, busy, done, carry, overflow, zero;
    logic [31:0] in1, in2, out;
    // sweep instance b: WIDTH=16, CHUNK=4
    logic        start_b, c_in_b, busy_b, done_b, carry_b, overflow_b, zero_b;
    logic [15:0] in1_b, in2_b, out_b;
    // sweep instance c: WIDTH=32, CHUNK=32
    logic        start_c, c_in_c, busy_c, done_c, carry_c, overflow_c, zero_c;
    logic [31:0] in1_c, in2_c, out_c;

    seq_addsub_unit #(.WIDTH(32), .CHUNK(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in1(in1), .in2(in2), .c_in(c_in),
        .busy(busy), .done(done), .out(out), .carry(carry), .overflow(overflow), .zero(zero));

    seq_addsub_unit #(.WIDTH(16), .CHUNK(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .in1(in1_b), .in2(in2_b), .c_in(c_in_b),
        .busy(busy_b), .done(done_b), .out(out_b), .carry(carry_b), .overflow(overflow_b),
        .zero(zero_b));

    seq_addsub_unit #(.WIDTH(32), .CHUNK(32)) dut_c (
        .clk(clk), .rst_n(rst_n), .start(start_c), .in1(in1_c), .in2(in2_c), .c_in(c_in_c),
        .busy(busy_c), .done(done_c), .out(out_c), .carry(carry_c), .overflow(overflow_c),
        .zero(zero_c));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic        sub;
        logic [31:0] eo;
        logic        ec;
        logic        ev;
        logic        ez;
    } vec_t;

    vec_t vecs[9];

    // returns {zero, overflow, carry, out} for a w-bit operation
    function automatic logic [34:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input int w);
        logic [63:0] mask, beff, full, res;
        logic        c, v, am, bm, om;
        mask = (64'd1 << w) - 64'd1;
        beff = (sub ? ~{32'd0, b} : {32'd0, b}) & mask;
        full = {32'd0, a} + beff + {63'd0, sub};
        res  = full & mask;
        c    = full[w];
        am   = a[w-1];
        bm   = beff[w-1];
        om   = res[w-1];
        v    = (am == bm) && (om != am);
`ifdef ADDSUB_SAT_EN
        if (v) res = am ? (64'd1 << (w-1)) : ((64'd1 << (w-1)) - 64'd1);
`endif
        return {(res == 64'd0), v, c, res[31:0]};
    endfunction

    // counts negedges until done is seen; -1 if it never arrives
    task automatic wait_done(output int cyc, output int bcnt);
        cyc  = -1;
        bcnt = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (done) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic sub);
        @(negedge clk);
        in1 = a; in2 = b; c_in = sub; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    logic [31:0] last_out;
    int          cyc, bcnt;
    logic        saw_done;
    logic [34:0] m;
    logic        seen_b, seen_c;

    initial begin
        vecs[0] = '{"add_ff_1",     32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"add_wrap",     32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{"sub_5_5",      32'h00000005, 32'h00000005, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
        vecs[3] = '{"sub_3_5",      32'h00000003, 32'h00000005, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"add_mix",      32'h12345678, 32'h9ABCDEF0, 1'b0, 32'hACF13568, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"sub_0_0",      32'h00000000, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0, 1'b1};
`ifdef ADDSUB_SAT_EN
        vecs[6] = '{"add_pos_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h7FFFFFFF, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{"sub_neg_ovf",  32'h80000000, 32'h00000001, 1'b1, 32'h80000000, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{"add_negneg",   32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 1'b1, 1'b1, 1'b0};
`else
        vecs[6] = '{"add_pos_ovf",  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{"sub_neg_ovf",  32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
        vecs[8] = '{"add_negneg",   32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1, 1'b1};
`endif

        rst_n = 1'b0;
        start = 1'b0; in1 = '0; in2 = '0; c_in = 1'b0;
        start_b = 1'b0; in1_b = '0; in2_b = '0; c_in_b = 1'b0;
        start_c = 1'b0; in1_c = '0; in2_c = '0; c_in_c = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_out",  {32'd0, out}, 64'd0);
        chk("rst_flags", {61'd0, carry, overflow, zero}, 64'd0);

        for (int i = 0; i < 9; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].sub);
            wait_done(cyc, bcnt);
            chk({vecs[i].name, "_latency"}, 64'(cyc - 1), 64'd4);
            chk({vecs[i].name, "_out"},  {32'd0, out}, {32'd0, vecs[i].eo});
            chk({vecs[i].name, "_flags"}, {61'd0, carry, overflow, zero},
                {61'd0, vecs[i].ec, vecs[i].ev, vecs[i].ez});
            @(negedge clk);
            if (!busy) begin
                bcnt = bcnt;
            end
            chk({vecs[i].name, "_busy_cycles"}, 64'(bcnt), 64'd5);
            chk({vecs[i].name, "_done_pulse"}, {62'd0, done, busy}, 64'd0);
        end
        last_out = vecs[8].eo;

        // restart attempts during RUN and DONE are ignored; operand changes too
        launch(32'h11111111, 32'h22222222, 1'b0);
        @(negedge clk);
        @(negedge clk);
        start = 1'b1; in1 = 32'hAAAAAAAA; in2 = 32'h00000005; c_in = 1'b1;
        @(negedge clk);
        start = 1'b0; in1 = 32'hDEADBEEF;
        chk("out_held_in_run", {32'd0, out}, {32'd0, last_out});
        wait_done(cyc, bcnt);
        chk("ignore_run_latency", 64'(cyc), 64'd2);
        chk("ignore_run_out", {32'd0, out}, 64'h33333333);
        chk("ignore_run_flags", {61'd0, carry, overflow, zero}, 64'd0);
        start = 1'b1; in1 = 32'h00000001; in2 = 32'h00000002; c_in = 1'b0;
        @(negedge clk);
        start = 1'b0;
        chk("start_in_done_ignored", {62'd0, busy, done}, 64'd0);
        start = 1'b1; in1 = 32'h00000010; in2 = 32'h00000003; c_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_after_done_taken", {63'd0, busy}, 64'd1);
        wait_done(cyc, bcnt);
        chk("after_done_latency", 64'(cyc), 64'd4);
        chk("after_done_out", {32'd0, out}, 64'h0000000D);
        chk("after_done_flags", {61'd0, carry, overflow, zero}, 64'b100);

        // reset in the middle of RUN (idx = 2 pending)
        launch(32'h01020304, 32'h10203040, 1'b0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midrst_busy_done", {62'd0, busy, done}, 64'd0);
        chk("midrst_out", {32'd0, out}, 64'd0);
        chk("midrst_flags", {61'd0, carry, overflow, zero}, 64'd0);
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done || busy) saw_done = 1'b1;
        end
        chk("midrst_no_done", {63'd0, saw_done}, 64'd0);
        launch(32'h01020304, 32'h10203040, 1'b0);
        wait_done(cyc, bcnt);
        chk("post_rst_latency", 64'(cyc - 1), 64'd4);
        chk("post_rst_out", {32'd0, out}, 64'h11223344);
        chk("post_rst_flags", {61'd0, carry, overflow, zero}, 64'd0);
        @(negedge clk);

        // random sweep on the 16/4 and 32/32 instances against the model
        for (int i = 0; i < 1000; i++) begin
            in1_b = 16'($urandom);
            in2_b = ($urandom_range(0, 7) == 0) ? in1_b : 16'($urandom);
            c_in_b = 1'($urandom);
            in1_c = $urandom;
            in2_c = ($urandom_range(0, 7) == 0) ? in1_c : $urandom;
            c_in_c = 1'($urandom);
            start_b = 1'b1; start_c = 1'b1;
            @(posedge clk);
            #1 start_b = 1'b0; start_c = 1'b0;
            seen_b = 1'b0; seen_c = 1'b0;
            for (int k = 1; k <= 20 && !(seen_b && seen_c); k++) begin
                @(negedge clk);
                if (done_b && !seen_b) begin
                    seen_b = 1'b1;
                    m = model({16'd0, in1_b}, {16'd0, in2_b}, c_in_b, 16);
                    chk("sw16_latency", 64'(k - 1), 64'd4);
                    chk("sw16_result", {45'd0, zero_b, overflow_b, carry_b, out_b},
                        {29'd0, m[34:32], m[15:0]});
                end
                if (done_c && !seen_c) begin
                    seen_c = 1'b1;
                    m = model(in1_c, in2_c, c_in_c, 32);
                    chk("sw32c_latency", 64'(k - 1), 64'd1);
                    chk("sw32c_result", {29'd0, zero_c, overflow_c, carry_c, out_c},
                        {29'd0, m});
                end
            end
            chk("sweep_done_seen", {62'd0, seen_b, seen_c}, 64'd3);
            @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_addsub_unit.md
Name: seq_addsub_unit

Overview:
- Parametrised, multi-cycle integer adder/subtractor; successor to the team's 8-bit combinational add/sub block.
- Processes WIDTH-bit operands CHUNK bits per clock with a registered ripple carry between slices.
- Uses a start/done handshake and returns carry, signed-overflow and zero flags.
- Sits beside the ALU datapath for wide operands where a single-cycle WIDTH-bit adder would not meet timing.

Parameters:
- WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits processed per cycle; NCHUNK = WIDTH/CHUNK, which is 1 or more.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  synchronous, active-low reset.
- start  input  1  request; sampled only in IDLE.
- in1  input  WIDTH  operand A.
- in2  input  WIDTH  operand B.
- c_in  input  1  mode: 0 = A+B, 1 = A-B (A + ~B + 1).
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse; results valid.
- out  output  WIDTH  result, held until the next completion.
- carry  output  1  carry out of the MSB; for subtract, 1 = no borrow.
- overflow  output  1  signed two's-complement overflow.
- zero  output  1  high when out == 0.

Behaviour:
- Reset: when rst_n is low at a rising edge, state goes to IDLE and busy, done, out, carry, overflow, zero all become 0. The slice index, accumulator and carry register clear. This applies mid-operation too: the in-flight operation is discarded and no done is generated.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k latches in1 and in2 (in2 inverted if c_in=1) and latches c_in as the initial slice carry.
  - Slice index goes to 0 and state goes to RUN.
  - start=0 stays in IDLE.
- RUN:
  - Each edge adds slice[idx] of A, slice[idx] of B_eff and the carry register.
  - The CHUNK-bit sum is written into the accumulator slice; the slice carry-out goes to the carry register; idx increments.
  - On the edge that processes idx = NCHUNK-1 (edge k+NCHUNK):
    - out <= full accumulator.
    - carry <= final slice carry.
    - overflow <= (A[MSB] == B_eff[MSB]) && (sum[MSB] != A[MSB]).
    - zero <= (sum == 0).
    - done <= 1; state goes to DONE.
- DONE: one cycle only. The next edge sets done to 0 and state to IDLE.
- Latency: done is high in the cycle after edge k+NCHUNK, i.e. NCHUNK cycles after the start edge.
- Throughput: one operation per NCHUNK+2 cycles.
- busy is high in the RUN and DONE cycles. start is ignored while busy, including in DONE.
- Operands are captured once; changes on in1, in2 or c_in after the start edge have no effect.
- out and the flags change only at completion; they do not show partial sums during RUN.
- All arithmetic is modulo 2^WIDTH; the carry register is 1 bit wide.
- NCHUNK = 1 degenerates to a single RUN cycle; the same handshake applies.

Optional Feature:
- Macro: ADDSUB_SAT_EN.
- Defined: signed saturation at completion. If overflow=1, out becomes 0111..1 when A[MSB]=0, else 1000..0. overflow and carry still report the raw (unsaturated) result, and zero is computed on the saturated out.
- Undefined: out is always the wrapped modulo result.

Test Plan (WIDTH=32, CHUNK=8 unless stated):
- Add 0x000000FF + 0x00000001, c_in=0 -> out=0x00000100, carry=0, ovf=0, zero=0. done pulses exactly 4 cycles after the start edge for one cycle; busy is high for 5 cycles. This checks inter-slice carry.
- Add 0xFFFFFFFF + 0x00000001 -> out=0, carry=1, zero=1, ovf=0. Sub 5-5 -> out=0, carry=1, zero=1, ovf=0. Sub 3-5 -> out=0xFFFFFFFE, carry=0, ovf=0.
- Add 0x7FFFFFFF + 1 -> out=0x80000000, ovf=1 (with ADDSUB_SAT_EN: out=0x7FFFFFFF, ovf=1). Sub 0x80000000-1 -> out=0x7FFFFFFF, ovf=1, carry=1 (with ADDSUB_SAT_EN: out=0x80000000).
- Pulse start again 2 cycles into RUN with different operands, and change in1 during RUN -> ignored; the first result is unchanged. A start in the DONE cycle is ignored. A start one cycle after DONE is accepted.
- Drop rst_n for 1 cycle at RUN idx=2 -> next cycle busy=0 and out=0 with all flags 0, no done pulse. A following start produces a correct result.
- Parameter sweep: CHUNK=32 (NCHUNK=1) and WIDTH=16/CHUNK=4. Run 1000 random add/sub ops against a reference model -> out and all flags match; latency equals NCHUNK.
